// File: rtl/ram_copy_engine.sv
// ============================================================================
// Module   : ram_copy_engine
// Purpose  : Word-at-a-time RAM-to-RAM copy engine with an asynchronous-read
//            RAM. Optional fill mode is enabled by `RAM_COPY_ENGINE_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_copy_engine #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] src_addr,
    input  logic [AWIDTH-1:0] dst_addr,
    input  logic [AWIDTH:0]   len,
`ifdef RAM_COPY_ENGINE_FILL_EN
    input  logic              fill_mode,
    input  logic [DWIDTH-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] rd_addr,
    input  logic [DWIDTH-1:0] rd_data,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              wr_en
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] src_q, src_d;
    logic [AWIDTH-1:0] dst_q, dst_d;
    logic [AWIDTH:0]   cnt_q, cnt_d;

`ifdef RAM_COPY_ENGINE_FILL_EN
    logic              fill_mode_q, fill_mode_d;
    logic [DWIDTH-1:0] fill_data_q, fill_data_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef RAM_COPY_ENGINE_FILL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_mode_q <= 1'b0;
            fill_data_q <= '0;
        end else begin
            fill_mode_q <= fill_mode_d;
            fill_data_q <= fill_data_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
`ifdef RAM_COPY_ENGINE_FILL_EN
        fill_mode_d = fill_mode_q;
        fill_data_d = fill_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A zero-length command skips COPY and leaves pointers untouched.
                    if (len != '0) begin
                        state_d = S_COPY;
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = len;
`ifdef RAM_COPY_ENGINE_FILL_EN
                        fill_mode_d = fill_mode;
                        fill_data_d = fill_data;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_COPY: begin
                src_d = src_q + 1'b1;
                dst_d = dst_q + 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == {{AWIDTH{1'b0}}, 1'b1}) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read and write share the cycle: the RAM read is combinational, so each
    // read sees every write committed on earlier edges of the same command.
    assign rd_addr = src_q;
    assign wr_addr = dst_q;
    assign wr_en   = (state_q == S_COPY) && !rst;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

`ifdef RAM_COPY_ENGINE_FILL_EN
    assign wr_data = fill_mode_q ? fill_data_q : rd_data;
`else
    assign wr_data = rd_data;
`endif

endmodule

`default_nettype wire

// File: doc/ram_copy_engine.md
RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

Interface
REQ-001 Parameter DWIDTH, default 8, data word width.
REQ-002 Parameter AWIDTH, default 8, RAM address width; depth is 2^AWIDTH words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  command request, sampled only in IDLE.
REQ-006 src_addr  input  AWIDTH  first source word address.
REQ-007 dst_addr  input  AWIDTH  first destination word address.
REQ-008 len  input  AWIDTH+1  number of words to transfer, 0 to 2^AWIDTH.
REQ-009 busy  output  1  high while a command is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rd_addr  output  AWIDTH  address to the RAM read port.
REQ-012 rd_data  input  DWIDTH  RAM read data, combinational from rd_addr (asynchronous read).
REQ-013 wr_addr  output  AWIDTH  address to the RAM write port.
REQ-014 wr_data  output  DWIDTH  RAM write data.
REQ-015 wr_en  output  1  RAM write enable; the RAM commits on the same rising edge.

Function
REQ-016 FSM states: IDLE, COPY, DONE.
REQ-017 In IDLE, start=1 with len!=0 latches src_addr, dst_addr and len; the next state is COPY.
REQ-018 In IDLE, start=1 with len==0 goes to DONE with no write issued.
REQ-019 start is ignored outside IDLE, and command inputs are never re-sampled mid-command.
REQ-020 In COPY each cycle: rd_addr=src pointer, wr_addr=dst pointer, wr_data=rd_data (same cycle), wr_en=1.
REQ-021 On each COPY edge both pointers increment by 1 modulo 2^AWIDTH (wrap 2^AWIDTH-1 -> 0) and the remaining count decrements.
REQ-022 COPY lasts exactly len cycles; when the remaining count is 1 the next state is DONE.
REQ-023 DONE lasts one cycle with done=1; the next state is IDLE, so a new start is accepted the cycle after done.
REQ-024 busy=1 in COPY and DONE, 0 in IDLE.
REQ-025 wr_en=0 in IDLE and DONE; wr_addr, wr_data and rd_addr hold their last pointer values there.
REQ-026 Overlapping regions produce the result of a sequential ascending word-by-word copy; each read observes all earlier writes of the same command.
REQ-027 Throughput is 1 word/cycle; command latency (start edge to done high) is len+1 cycles.

Reset
REQ-028 rst=1 at a rising edge forces IDLE and clears both pointers and the count to 0.
REQ-029 Reset values: busy=0, done=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=rd_data of address 0.
REQ-030 wr_en is gated by rst, so no RAM write occurs in any cycle where rst=1, including reset asserted mid-COPY.
REQ-031 A command aborted by reset produces no done pulse; words written before the reset remain written.

Configuration
REQ-032 Macro RAM_COPY_ENGINE_FILL_EN, when defined, adds inputs fill_mode (1 bit) and fill_data (DWIDTH), both latched at command accept.
REQ-033 With the macro defined and latched fill_mode=1, wr_data equals latched fill_data and rd_data is ignored; timing is identical to copy mode.
REQ-034 Without the macro, fill_mode and fill_data do not exist and every command is a copy.

Verification
REQ-035 RAM preloaded mem[i]=i; start, src=0x10, dst=0x80, len=4 -> wr_en high 4 cycles, mem[0x80..0x83]=0x10..0x13, done 5 cycles after start edge, busy high 5 cycles.
REQ-036 start with len=0 -> no wr_en, done the following cycle, RAM unchanged.
REQ-037 src=0xFE, dst=0x40, len=4 -> reads 0xFE, 0xFF, 0x00, 0x01 (wrap), mem[0x40..0x43]=0xFE, 0xFF, 0x00, 0x01.
REQ-038 Overlap src=0x00, dst=0x01, len=3 with mem[0..3]=A,B,C,D -> mem[0..3]=A,A,A,A (sequential ascending semantics).
REQ-039 rst pulsed in the 3rd COPY cycle of len=8 -> exactly 2 words written, no write in the reset cycle, no done, busy=0 next cycle; start during COPY ignored.
REQ-040 FILL_EN build: fill_mode=1, fill_data=0xA5, dst=0x20, len=3 -> mem[0x20..0x22]=0xA5, done at cycle 4.
